// File: rtl/lif_array_scheduler.sv
// Time-multiplexed leaky-integrate-and-fire scheduler: one shared update datapath
// sweeps N_NEURONS virtual neurons per timestep and streams spike indices out.
module lif_array_scheduler #(
    parameter int unsigned N_NEURONS  = 8,
    parameter int unsigned W          = 8,
    parameter int unsigned THRESHOLD  = 64,
    parameter int unsigned LEAK_SHIFT = 2,
    parameter int unsigned REFRAC     = 4,
    localparam int unsigned IDX_W     = $clog2(N_NEURONS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             in_we,
    input  logic [IDX_W-1:0] in_idx,
    input  logic [W-1:0]     in_data,
    output logic             spk_valid,
    output logic [IDX_W-1:0] spk_idx,
    input  logic             spk_ready,
    output logic             busy,
    output logic             done,
    output logic             overrun
);

    localparam int unsigned R_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        FLUSH  = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [W-1:0]     v_q   [N_NEURONS];
    logic [W-1:0]     v_d   [N_NEURONS];
    logic [R_W-1:0]   r_q   [N_NEURONS];
    logic [R_W-1:0]   r_d   [N_NEURONS];
    logic [W-1:0]     buf_q [N_NEURONS];
    logic [W-1:0]     buf_d [N_NEURONS];

    logic [IDX_W-1:0] idx_q, idx_d;
    logic             spk_valid_q, spk_valid_d;
    logic [IDX_W-1:0] spk_idx_q, spk_idx_d;
    logic             done_q, done_d;
    logic             overrun_q, overrun_d;
    logic             busy_q, busy_d;

    logic             out_free;
    logic             commit;
    logic             last;
    logic             in_ok;
    logic [W-1:0]     cur_v, cur_i, leak, s_sat;
    logic [R_W-1:0]   cur_r;
    logic [W:0]       sum;
    logic             fire;

    // Shared update datapath for the neuron currently addressed by idx_q
    always_comb begin
        out_free = !spk_valid_q || spk_ready;
        commit   = (state_q == UPDATE) && out_free;
        last     = (idx_q == IDX_W'(N_NEURONS - 1));
        in_ok    = in_we && (32'(in_idx) < N_NEURONS);
        cur_v    = v_q[idx_q];
        cur_r    = r_q[idx_q];
        cur_i    = buf_q[idx_q];
        leak     = cur_v >> LEAK_SHIFT;
        sum      = (W+1)'(cur_v) - (W+1)'(leak) + (W+1)'(cur_i);
        s_sat    = sum[W] ? '1 : sum[W-1:0];
        fire     = (cur_r == '0) && (32'(s_sat) >= THRESHOLD);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; a tick coinciding with done is treated as an overrun
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (tick && !done_q) state_d = UPDATE;
            UPDATE:  if (commit && last)  state_d = FLUSH;
            FLUSH:   if (out_free)        state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next-values
    always_comb begin
        logic [W:0] add_tmp;
        add_tmp     = '0;
        idx_d       = idx_q;
        spk_valid_d = spk_valid_q;
        spk_idx_d   = spk_idx_q;
        done_d      = (state_q == FLUSH) && out_free;
        overrun_d   = overrun_q || (tick && ((state_q != IDLE) || done_q));
        busy_d      = (state_d != IDLE);
        v_d         = v_q;
        r_d         = r_q;
        buf_d       = buf_q;

        if (state_q == IDLE && tick && !done_q) idx_d = '0;
        if (commit && !last) idx_d = idx_q + IDX_W'(1);

        if (spk_valid_q && spk_ready) spk_valid_d = 1'b0;
        if (commit && fire) begin
            spk_valid_d = 1'b1;
            spk_idx_d   = idx_q;
        end

        for (int unsigned n = 0; n < N_NEURONS; n++) begin
            if (commit && idx_q == IDX_W'(n)) begin
                if (cur_r != '0) begin
                    r_d[n] = cur_r - R_W'(1);
                    v_d[n] = '0;
                end else if (fire) begin
                    r_d[n] = R_W'(REFRAC);
                    v_d[n] = '0;
                end else begin
                    v_d[n] = s_sat;
                end
                buf_d[n] = '0;
            end
            // A write racing the commit of the same neuron belongs to the next timestep
            if (in_ok && in_idx == IDX_W'(n)) begin
                add_tmp = (W+1)'(buf_q[n]) + (W+1)'(in_data);
                if (commit && idx_q == IDX_W'(n)) buf_d[n] = in_data;
                else                              buf_d[n] = add_tmp[W] ? '1 : add_tmp[W-1:0];
            end
        end
    end

    // Register file and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned n = 0; n < N_NEURONS; n++) begin
                v_q[n]   <= '0;
                r_q[n]   <= '0;
                buf_q[n] <= '0;
            end
            idx_q       <= '0;
            spk_valid_q <= 1'b0;
            spk_idx_q   <= '0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            for (int unsigned n = 0; n < N_NEURONS; n++) begin
                v_q[n]   <= v_d[n];
                r_q[n]   <= r_d[n];
                buf_q[n] <= buf_d[n];
            end
            idx_q       <= idx_d;
            spk_valid_q <= spk_valid_d;
            spk_idx_q   <= spk_idx_d;
            done_q      <= done_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
        end
    end

    assign spk_valid = spk_valid_q;
    assign spk_idx   = spk_idx_q;
    assign done      = done_q;
    assign overrun   = overrun_q;
    assign busy      = busy_q;

endmodule
